// File: rtl/imem_responder.sv
// imem_responder: instruction memory that is filled by a loader and then serves 1-cycle fetches.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag mismatches on resp_perr.
module imem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [4:0]  EXC_ADEL    = 5'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic        run,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic        hold,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_exc,
   output logic        resp_perr
);
   typedef enum logic {LOAD, RUN} state_t;
   localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS - 4);
   state_t state;
   logic [11:0] wptr, idx;
   logic [31:0] mem [DEPTH_WORDS];
   // Per-word written flags give the reset-to-zero view without clearing the array itself.
   logic [DEPTH_WORDS-1:0] wr;
   logic ld_acc, to_run, req_acc, bad;
   logic [31:0] rd;
   assign ld_acc    = ld_valid & ld_ready;
   assign to_run    = ld_acc & (ld_last | (wptr == 12'(DEPTH_WORDS - 1)));
   assign req_ready = run & ~hold;
   assign req_acc   = req_valid & req_ready;
   assign bad       = (|req_addr[1:0]) | (req_addr < BASE_ADDR) | (req_addr > LAST_ADDR);
   assign idx       = 12'((req_addr - BASE_ADDR) >> 2);
   assign rd        = (bad || !wr[idx]) ? '0 : mem[idx];
   always_ff @(posedge clk) begin
      if (ld_acc) mem[wptr] <= ld_data;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LOAD;
         wptr       <= '0;
         ld_ready   <= 1'b0;
         run        <= 1'b0;
         wr         <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_exc   <= '0;
      end else begin
         if (ld_acc) begin
            wr[wptr] <= 1'b1;
            wptr     <= to_run ? wptr : wptr + 12'd1;
         end
         state    <= (state == RUN || to_run) ? RUN : LOAD;
         run      <= state == RUN || to_run;
         ld_ready <= state == LOAD && !to_run;
         if (!hold) begin
            resp_valid <= req_acc;
            if (req_acc) begin
               resp_data <= rd;
               resp_exc  <= bad ? EXC_ADEL : '0;
            end
         end
      end
   end
`ifdef IMEM_PARITY_EN
   logic [DEPTH_WORDS-1:0] par;
   always_ff @(posedge clk) begin
      if (ld_acc) par[wptr] <= ^ld_data;
   end
   always_ff @(posedge clk) begin
      if (reset) resp_perr <= 1'b0;
      else if (!hold) resp_perr <= req_acc && !bad && wr[idx] && ((^mem[idx]) != par[idx]);
   end
`else
   assign resp_perr = 1'b0;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed self-checking bench for imem_responder.
module tb_imem_responder;
   logic clk = 0, reset = 1, ld_valid = 0, ld_last = 0, req_valid = 0, hold = 0;
   logic [31:0] ld_data = 0, req_addr = 0;
   logic ld_ready, run, req_ready, resp_valid, resp_perr;
   logic [31:0] resp_data;
   logic [4:0] resp_exc;
   int checks = 0, fails = 0;

   imem_responder dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .run(run), .req_valid(req_valid), .req_addr(req_addr), .hold(hold),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_exc(resp_exc), .resp_perr(resp_perr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      step();
      reset = 0;
      step();
   endtask

   task automatic load_word(input logic [31:0] d, input logic l);
      ld_valid = 1;
      ld_data = d;
      ld_last = l;
      step();
      ld_valid = 0;
      ld_last = 0;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input logic [4:0] ee,
                        input logic ep, input string nm);
      req_valid = 1;
      req_addr = a;
      step();
      req_valid = 0;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== ed || resp_exc !== ee || resp_perr !== ep) begin
         fails++;
         $display("FAIL %s: valid=%b data=%h exc=%0d perr=%b, want valid=1 data=%h exc=%0d perr=%b",
                  nm, resp_valid, resp_data, resp_exc, resp_perr, ed, ee, ep);
      end
   endtask

   task automatic test_reset();
      reset = 1;
      step();
      step();
      checks++;
      if ({run, req_ready, resp_valid, resp_data, resp_exc, resp_perr, ld_ready} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: run=%b rr=%b rv=%b data=%h exc=%0d perr=%b ldr=%b, want all 0",
                  run, req_ready, resp_valid, resp_data, resp_exc, resp_perr, ld_ready);
      end
      reset = 0;
      step();
      checks++;
      if (ld_ready !== 1'b1 || run !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: ld_ready=%b run=%b, want 1 0", ld_ready, run);
      end
   endtask

   task automatic test_load_ignores_req();
      req_valid = 1;
      req_addr = 32'h3000;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         fails++;
         $display("FAIL load_req_ready: got %b want 0", req_ready);
      end
      step();
      req_valid = 0;
      checks++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL load_no_resp: resp_valid=%b want 0", resp_valid);
      end
   endtask

   task automatic test_basic();
      load_word(32'h1111_1111, 0);
      load_word(32'h2222_2222, 0);
      load_word(32'h3333_3333, 1);
      step();
      checks++;
      if (run !== 1'b1 || ld_ready !== 1'b0 || req_ready !== 1'b1) begin
         fails++;
         $display("FAIL basic_run: run=%b ld_ready=%b req_ready=%b, want 1 0 1", run, ld_ready, req_ready);
      end
      fetch(32'h3004, 32'h2222_2222, 5'd0, 0, "fetch_3004");
      fetch(32'h3000, 32'h1111_1111, 5'd0, 0, "fetch_3000");
      fetch(32'h3008, 32'h3333_3333, 5'd0, 0, "fetch_3008");
      fetch(32'h300c, 32'h0, 5'd0, 0, "fetch_unwritten");
      step();
      checks++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL idle_deassert: resp_valid=%b want 0", resp_valid);
      end
   endtask

   task automatic test_addr_err();
      fetch(32'h3002, 32'h0, 5'd4, 0, "err_misaligned");
      fetch(32'h2ffc, 32'h0, 5'd4, 0, "err_below");
      fetch(32'h7000, 32'h0, 5'd4, 0, "err_above");
      fetch(32'h6ffc, 32'h0, 5'd0, 0, "top_word_ok");
   endtask

   task automatic test_hold();
      fetch(32'h3000, 32'h1111_1111, 5'd0, 0, "hold_first");
      for (int k = 0; k < 3; k++) begin
         hold = 1;
         req_valid = 1;
         req_addr = 32'h3004 + 32'(4 * k);
         #1;
         checks++;
         if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_req_ready[%0d]: got %b want 0", k, req_ready);
         end
         step();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== 32'h1111_1111 || resp_exc !== 5'd0) begin
            fails++;
            $display("FAIL hold_stable[%0d]: valid=%b data=%h exc=%0d, want 1 11111111 0",
                     k, resp_valid, resp_data, resp_exc);
         end
      end
      hold = 0;
      fetch(32'h3008, 32'h3333_3333, 5'd0, 0, "hold_release");
   endtask

   task automatic test_run_ignores_loader();
      ld_valid = 1;
      ld_data = 32'hDEAD_BEEF;
      step();
      ld_valid = 0;
      checks++;
      if (ld_ready !== 1'b0 || run !== 1'b1) begin
         fails++;
         $display("FAIL run_loader: ld_ready=%b run=%b, want 0 1", ld_ready, run);
      end
      fetch(32'h300c, 32'h0, 5'd0, 0, "run_no_write");
   endtask

   task automatic test_parity();
`ifdef IMEM_PARITY_EN
      force dut.par[1] = 1'b1;
      fetch(32'h3004, 32'h2222_2222, 5'd0, 1, "parity_error");
      release dut.par[1];
`else
      fetch(32'h3004, 32'h2222_2222, 5'd0, 0, "parity_off");
`endif
   endtask

   task automatic test_reset_mid_run();
      reset = 1;
      step();
      checks++;
      if ({run, req_ready, resp_valid, resp_data, resp_exc, resp_perr} !== '0) begin
         fails++;
         $display("FAIL midrun_reset: run=%b rr=%b rv=%b data=%h exc=%0d perr=%b, want all 0",
                  run, req_ready, resp_valid, resp_data, resp_exc, resp_perr);
      end
      reset = 0;
      step();
      checks++;
      if (ld_ready !== 1'b1 || run !== 1'b0) begin
         fails++;
         $display("FAIL midrun_reload: ld_ready=%b run=%b, want 1 0", ld_ready, run);
      end
      load_word(32'hABCD_0123, 1);
      step();
      fetch(32'h3004, 32'h0, 5'd0, 0, "cleared_word1");
      fetch(32'h3000, 32'hABCD_0123, 5'd0, 0, "reload_word0");
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4096; i++) load_word(32'hA500_0000 | 32'(i), 0);
      checks++;
      if (run !== 1'b1 || ld_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_auto_run: run=%b ld_ready=%b, want 1 0", run, ld_ready);
      end
      load_word(32'hDEAD_BEEF, 0);
      fetch(32'h6ffc, 32'hA500_0FFF, 5'd0, 0, "full_last");
      fetch(32'h4180, 32'hA500_0460, 5'd0, 0, "full_460");
      fetch(32'h3000, 32'hA500_0000, 5'd0, 0, "full_no_wrap");
   endtask

   initial begin
      test_reset();
      test_load_ignores_req();
      test_basic();
      test_addr_err();
      test_hold();
      test_run_ignores_loader();
      test_parity();
      test_reset_mid_run();
      test_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 32'h0000_3000, byte address of word 0. DEPTH_WORDS, 4096, number of 32-bit words. EXC_ADEL, 5'd4, fetch address-error code.
REQ-002 Ports SHALL be as follows; reset is synchronous, active-high; the clock is clk:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- ld_valid  in  1  loader word present
- ld_data  in  32  loader word
- ld_last  in  1  final loader word
- ld_ready  out  1  loader word accepted this cycle
- run  out  1  fetch service enabled
- req_valid  in  1  fetch request
- req_addr  in  32  fetch byte address
- hold  in  1  pipeline freeze
- req_ready  out  1  request accepted this cycle
- resp_valid  out  1  response present
- resp_data  out  32  instruction word
- resp_exc  out  5  exception code, 0 = none
- resp_perr  out  1  parity error

Function
REQ-003 The FSM SHALL have two states: LOAD (after reset) and RUN.
REQ-004 In LOAD, ld_ready SHALL equal 1; each cycle with ld_valid=1, ld_data SHALL be written to word wptr, and wptr SHALL increment.
REQ-005 wptr SHALL be 12 bits and reset to 0.
REQ-006 LOAD->RUN SHALL occur on the cycle after an accepted word with ld_last=1, or with wptr=DEPTH_WORDS-1 (memory full); wptr SHALL NOT wrap.
REQ-007 In RUN, ld_ready SHALL be 0 and ld_valid SHALL be ignored; RUN is left only by reset.
REQ-008 run SHALL be 1 exactly in RUN.
REQ-009 req_ready SHALL equal run & ~hold; a request is accepted when req_valid & req_ready.
REQ-010 Read latency SHALL be 1 cycle: an accepted request at cycle N SHALL produce resp_valid=1 with its data at cycle N+1.
REQ-011 A response SHALL be deasserted (resp_valid=0) in the cycle after a cycle with no accepted request and hold=0.
REQ-012 While hold=1, resp_valid, resp_data, resp_exc and resp_perr SHALL keep their values.
REQ-013 Address error: a fetch SHALL be flagged if req_addr[1:0]!=0, req_addr<BASE_ADDR, or req_addr>BASE_ADDR+4*DEPTH_WORDS-4.
REQ-014 On a flagged fetch, the response SHALL give resp_exc=EXC_ADEL and resp_data=0, and memory SHALL NOT be read.
REQ-015 The word index SHALL be (req_addr-BASE_ADDR)>>2, truncated to 12 bits.
REQ-016 A word never written during LOAD SHALL read as 0.
REQ-017 req_valid during LOAD SHALL be ignored: req_ready=0, and no response is produced.

Reset
REQ-018 On reset, the block SHALL enter LOAD with wptr=0 and all outputs cleared (run=0, req_ready=0, resp_valid=0, resp_data=0, resp_exc=0, resp_perr=0); ld_ready SHALL be 1 from the cycle after reset deasserts.
REQ-019 Memory contents SHALL be cleared to 0 by reset, including a reset asserted mid-LOAD or mid-RUN; any pending response SHALL be discarded.

Configuration
REQ-020 With macro IMEM_PARITY_EN defined:
- each stored word SHALL carry an even-parity bit computed on write;
- a read with mismatching parity SHALL set resp_perr=1 with the data unchanged.
REQ-021 Without IMEM_PARITY_EN, no parity storage SHALL exist and resp_perr SHALL be constant 0.

Verification
REQ-022 Reset, then load 0x11111111, 0x22222222 and 0x33333333 (last) -> run=1 two cycles after the last word; fetch 0x3004 -> resp_data=0x22222222 next cycle, resp_exc=0.
REQ-023 Fetch 0x3002, 0x2ffc and 0x7000 -> each response has resp_exc=4 and resp_data=0.
REQ-024 Load 4096 words without ld_last -> auto RUN after word 4095, ld_ready=0; fetch 0x6ffc -> last word; fetch 0x4180 -> word 0x460.
REQ-025 Fetch 0x3000, then hold=1 for 3 cycles with req_addr changing -> response for 0x3000 stays stable and req_ready=0; after release, the next request is served with 1-cycle latency.
REQ-026 Reset asserted mid-RUN -> outputs are 0, run=0 and ld_ready=1; a fetch after reloading 1 word shows the unwritten word 1 reads 0.
REQ-027 With IMEM_PARITY_EN, force a stored parity bit flipped -> resp_perr=1; without the macro, resp_perr=0.
